// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and buffers {PC, instruction}
// in a small FIFO feeding decode. Optional misaligned-redirect trap via FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          FQ_DEPTH  = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               PC,
    input  logic [31:0]               Instruction,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    input  logic                      id_ready,
    output logic                      id_valid,
    output logic [31:0]               id_instr,
    output logic [31:0]               id_pc,
    output logic [$clog2(FQ_DEPTH):0] fq_count,
    output logic                      fetch_fault
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    logic [31:0]   pc_reg, pc_next;
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          fault_reg, fault_next;
    logic [31:0]   fq_pc_reg    [FQ_DEPTH];
    logic [31:0]   fq_instr_reg [FQ_DEPTH];

    logic          deq;
    logic          fetch;
    logic          misalign;
    logic [31:0]   target_pc;

    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign  = |redirect_pc[1:0];
        target_pc = redirect_pc;
`else
        misalign  = 1'b0;
        target_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end

    assign id_valid = (count_reg != '0);
    assign deq      = id_valid & id_ready;
    // A dequeue frees a slot this same edge, so a full queue can still fetch while decode drains it.
    assign fetch    = ~redirect & ~fault_reg & ((count_reg < DEPTH_C) | deq);

    always_comb begin
        pc_next    = pc_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        fault_next = fault_reg;
        if (redirect) begin
            pc_next    = target_pc;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            fault_next = misalign;
        end else begin
            if (fetch) begin
                pc_next   = pc_reg + 32'd4;
                tail_next = tail_reg + 1'b1;
            end
            if (deq) begin
                head_next = head_reg + 1'b1;
            end
            case ({fetch, deq})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg    <= RESET_PC;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            fault_reg <= fault_next;
        end
    end

    // Queue storage needs no reset: entries are only observed when counted as valid.
    always_ff @(posedge clk) begin
        if (fetch) begin
            fq_pc_reg[tail_reg]    <= pc_reg;
            fq_instr_reg[tail_reg] <= Instruction;
        end
    end

    assign PC          = pc_reg;
    assign id_instr    = id_valid ? fq_instr_reg[head_reg] : NOP_INSTR;
    assign id_pc       = id_valid ? fq_pc_reg[head_reg] : 32'h0;
    assign fq_count    = count_reg;
    assign fetch_fault = fault_reg;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scoreboard of expected {pc, instr} per handshake.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, redirect, id_ready;
    logic [31:0] redirect_pc;
    logic [31:0] PC, Instruction, id_instr, id_pc;
    logic        id_valid, fetch_fault;
    logic [1:0]  fq_count;

    logic        reset_w;
    logic [31:0] pc_w, instr_w, id_instr_w, id_pc_w;
    logic        id_valid_w, fault_w;
    logic [1:0]  count_w;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q [$];

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0194_0333;
            32'h0000_0004: return 32'h0039_0393;
            32'h0000_0008: return 32'h0024_a603;
            32'h0000_0014: return 32'h0040_00ef;
            default:       return {8'hA5, a[23:0]};
        endcase
    endfunction

    always_comb Instruction = imem_word(PC);
    always_comb instr_w     = imem_word(pc_w);

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .PC(PC), .Instruction(Instruction),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .fq_count(fq_count), .fetch_fault(fetch_fault)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset_w), .PC(pc_w), .Instruction(instr_w),
        .redirect(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
        .id_valid(id_valid_w), .id_instr(id_instr_w), .id_pc(id_pc_w),
        .fq_count(count_w), .fetch_fault(fault_w)
    );

    task automatic hold_reset();
        reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        checks++; if (fq_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fq_count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_stream();
        int n;
        logic [31:0] exp;
        hold_reset();
        id_ready = 1'b1; reset = 1'b1;
        sb_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            if (n > 0) begin
                checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_gap: id_valid=%b want 1 at cycle %0d", id_valid, n); end
                checks++; if (fq_count > 2'd1) begin errors++; $display("FAIL stream_count: fq_count=%0d want <=1", fq_count); end
            end
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                $display("stream txn pc=%h instr=%h", id_pc, id_instr);
                checks++; if (id_pc !== exp || id_instr !== imem_word(exp)) begin errors++;
                    $display("FAIL stream_txn: got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, exp, imem_word(exp)); end
            end
            @(negedge clk); n++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stream_timeout: %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] exp;
        hold_reset();
        id_ready = 1'b0; reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++;
                $display("FAIL stall_head: got valid=%b pc=%h want 1/00000000", id_valid, id_pc); end
        end
        checks++; if (fq_count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", fq_count); end
        checks++; if (PC !== 32'h8) begin errors++; $display("FAIL stall_pc: got %h want 00000008", PC); end
        id_ready = 1'b1;
        sb_q = {32'h0, 32'h4, 32'h8, 32'hC};
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                $display("stall txn pc=%h instr=%h", id_pc, id_instr);
                checks++; if (id_pc !== exp || id_instr !== imem_word(exp)) begin errors++;
                    $display("FAIL stall_txn: got pc=%h instr=%h want pc=%h", id_pc, id_instr, exp); end
            end
            @(negedge clk); n++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stall_timeout: %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_redirect();
        int n;
        logic [31:0] exp;
        hold_reset();
        id_ready = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fq_count !== 2'd2) begin errors++; $display("FAIL redir_full: got %0d want 2", fq_count); end
        redirect = 1'b1; redirect_pc = 32'h14;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (fq_count !== 2'd0 || id_valid !== 1'b0) begin errors++;
            $display("FAIL redir_flush: got count=%0d valid=%b want 0/0", fq_count, id_valid); end
        checks++; if (PC !== 32'h14 || id_instr !== 32'h13) begin errors++;
            $display("FAIL redir_pc: got PC=%h instr=%h want 00000014/00000013", PC, id_instr); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== 32'h0040_00ef) begin errors++;
            $display("FAIL redir_target: got valid=%b pc=%h instr=%h want 1/00000014/004000ef", id_valid, id_pc, id_instr); end
        id_ready = 1'b1;
        sb_q = {32'h14, 32'h20, 32'h24};
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            if (n == 1) begin
                checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_deq_flush: valid=%b want 0", id_valid); end
            end
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                $display("redirect txn pc=%h instr=%h", id_pc, id_instr);
                checks++; if (id_pc !== exp || id_instr !== imem_word(exp)) begin errors++;
                    $display("FAIL redir_txn: got pc=%h instr=%h want pc=%h", id_pc, id_instr, exp); end
            end
            redirect = (n == 0); redirect_pc = 32'h20;
            @(negedge clk); n++;
        end
        redirect = 1'b0;
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL redir_timeout: %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_wrap();
        int n;
        logic [31:0] exp;
        checks++; if (pc_w !== 32'hFFFF_FFFC || id_valid_w !== 1'b0) begin errors++;
            $display("FAIL wrap_reset: got PC=%h valid=%b want fffffffc/0", pc_w, id_valid_w); end
        reset_w = 1'b1;
        sb_q = {32'hFFFF_FFFC, 32'h0, 32'h4};
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            if (id_valid_w) begin
                exp = sb_q.pop_front();
                $display("wrap txn pc=%h instr=%h", id_pc_w, id_instr_w);
                checks++; if (id_pc_w !== exp || id_instr_w !== imem_word(exp)) begin errors++;
                    $display("FAIL wrap_txn: got pc=%h instr=%h want pc=%h", id_pc_w, id_instr_w, exp); end
            end
            @(negedge clk); n++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_midrun_reset();
        hold_reset();
        id_ready = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (PC !== 32'h0 || fq_count !== 2'd0 || id_valid !== 1'b0) begin errors++;
            $display("FAIL midrst_state: got PC=%h count=%0d valid=%b want 0/0/0", PC, fq_count, id_valid); end
        checks++; if (id_instr !== 32'h13 || id_pc !== 32'h0 || fetch_fault !== 1'b0) begin errors++;
            $display("FAIL midrst_out: got instr=%h pc=%h fault=%b want 00000013/0/0", id_instr, id_pc, fetch_fault); end
        @(negedge clk);
        checks++; if (PC !== 32'h0 || id_valid !== 1'b0) begin errors++;
            $display("FAIL midrst_hold: got PC=%h valid=%b want 0/0", PC, id_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0194_0333) begin errors++;
            $display("FAIL midrst_restart: got valid=%b pc=%h instr=%h want 1/0/01940333", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_misalign();
        hold_reset();
        id_ready = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h16;
        @(negedge clk);
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0 || PC !== 32'h16) begin errors++;
            $display("FAIL mis_fault: got fault=%b valid=%b PC=%h want 1/0/00000016", fetch_fault, id_valid, PC); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0) begin errors++;
                $display("FAIL mis_halt: got fault=%b valid=%b want 1/0", fetch_fault, id_valid); end
        end
        redirect = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mis_clear: got fault=%b want 0", fetch_fault); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++;
            $display("FAIL mis_resume: got valid=%b pc=%h want 1/0", id_valid, id_pc); end
`else
        checks++; if (fetch_fault !== 1'b0 || PC !== 32'h14) begin errors++;
            $display("FAIL mis_align: got fault=%b PC=%h want 0/00000014", fetch_fault, PC); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== 32'h0040_00ef) begin errors++;
            $display("FAIL mis_target: got valid=%b pc=%h instr=%h want 1/00000014/004000ef", id_valid, id_pc, id_instr); end
`endif
    endtask

    initial begin
        reset_w = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_midrun_reset();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
